// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header stripper: drops the first (strip_cnt+1) bytes of each packet and
// realigns the payload so every non-last output beat is full. Output is one registered beat.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic                    drop_pkt
);

   localparam int CW = BYTE_CNT_WD + 1;
   localparam logic [CW-1:0] W_BYTES = CW'(DATA_BYTE_WD);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   state_t                    r_state;
   logic [DATA_WD-1:0]        r_res_data;
   logic [CW-1:0]             r_res_cnt;
   logic                      r_valid_out;
   logic [DATA_WD-1:0]        r_data_out;
   logic [DATA_BYTE_WD-1:0]   r_keep_out;
   logic                      r_last_out;
   logic                      r_drop_pkt;

   state_t                    w_state_nxt;
   logic [DATA_WD-1:0]        w_res_data_nxt;
   logic [CW-1:0]             w_res_cnt_nxt;
   logic                      w_emit;
   logic [DATA_WD-1:0]        w_out_data;
   logic [DATA_BYTE_WD-1:0]   w_out_keep;
   logic                      w_out_last;
   logic                      w_drop;

   logic                      w_adv;
   logic                      w_hs;
   logic [CW-1:0]             w_s;
   logic [CW-1:0]             w_n;
   logic [CW-1:0]             w_tot;
   logic [DATA_WD-1:0]        w_data_m;
   logic [DATA_WD-1:0]        w_shl;
   logic [2*DATA_WD-1:0]      w_cat;

   // MSB-packed byte enable with n ones; n=0 gives all zeros, n=W all ones.
   function automatic logic [DATA_BYTE_WD-1:0] f_keep_mask(input logic [CW-1:0] n);
      f_keep_mask = ~({DATA_BYTE_WD{1'b1}} >> n);
   endfunction

   assign w_adv    = !r_valid_out || ready_out;
   assign ready_in = w_adv && (r_state != FLUSH);
   assign w_hs     = valid_in && ready_in;
   assign w_s      = {1'b0, strip_cnt} + CW'(1);
   assign w_tot    = r_res_cnt + w_n;

   // Invalid lanes are zeroed up front so realigned beats are zero-filled automatically.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_n      = '0;
      w_data_m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         w_n = w_n + CW'(keep_in[i]);
         w_data_m[i*8 +: 8] = keep_in[i] ? data_in[i*8 +: 8] : 8'h00;
      end
   end

   // Residue sits in the top lanes; the new beat is slid in right behind it.
   assign w_shl = w_data_m << {w_s, 3'b000};
   assign w_cat = {r_res_data, {DATA_WD{1'b0}}}
                | ({w_data_m, {DATA_WD{1'b0}}} >> {r_res_cnt, 3'b000});

   always_comb begin
      w_state_nxt    = r_state;
      w_res_data_nxt = r_res_data;
      w_res_cnt_nxt  = r_res_cnt;
      w_emit         = 1'b0;
      w_out_data     = '0;
      w_out_keep     = '0;
      w_out_last     = 1'b0;
      w_drop         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_hs) begin
               if (!last_in) begin
                  w_res_data_nxt = w_shl;
                  w_res_cnt_nxt  = W_BYTES - w_s;
                  w_state_nxt    = STREAM;
               end else if (w_n > w_s) begin
                  w_emit     = 1'b1;
                  w_out_data = w_shl;
                  w_out_keep = f_keep_mask(w_n - w_s);
                  w_out_last = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
         STREAM: begin
            if (w_hs) begin
               w_emit     = 1'b1;
               w_out_data = w_cat[2*DATA_WD-1 -: DATA_WD];
               if (!last_in) begin
                  w_out_keep     = '1;
                  w_res_data_nxt = w_cat[DATA_WD-1:0];
               end else if (w_tot <= W_BYTES) begin
                  w_out_keep     = f_keep_mask(w_tot);
                  w_out_last     = 1'b1;
                  w_res_data_nxt = '0;
                  w_res_cnt_nxt  = '0;
                  w_state_nxt    = IDLE;
               end else begin
                  w_out_keep     = '1;
                  w_res_data_nxt = w_cat[DATA_WD-1:0];
                  w_res_cnt_nxt  = w_tot - W_BYTES;
                  w_state_nxt    = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (w_adv) begin
               w_emit         = 1'b1;
               w_out_data     = r_res_data;
               w_out_keep     = f_keep_mask(r_res_cnt);
               w_out_last     = 1'b1;
               w_res_data_nxt = '0;
               w_res_cnt_nxt  = '0;
               w_state_nxt    = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_res_data  <= '0;
         r_res_cnt   <= '0;
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
         r_keep_out  <= '0;
         r_last_out  <= 1'b0;
         r_drop_pkt  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_res_data <= w_res_data_nxt;
         r_res_cnt  <= w_res_cnt_nxt;
         r_drop_pkt <= w_drop;
         if (w_adv) begin
            r_valid_out <= w_emit;
            r_data_out  <= w_out_data;
            r_keep_out  <= w_out_keep;
            r_last_out  <= w_out_last;
         end
      end
   end

   assign valid_out = r_valid_out;
   assign data_out  = r_data_out;
   assign keep_out  = r_keep_out;
   assign last_out  = r_last_out;
   assign drop_pkt  = r_drop_pkt;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header: directed cases plus random packets,
// compared against a byte-queue model of the strip-and-repack behaviour.
module tb_axi_stream_strip_header;

   localparam int DATA_WD = 32;
   localparam int W       = DATA_WD / 8;
   localparam int LIMIT   = 1000;

   logic              clk;
   logic              rst_n;
   logic              valid_in;
   logic [DATA_WD-1:0] data_in;
   logic [W-1:0]      keep_in;
   logic              last_in;
   logic              ready_in;
   logic [1:0]        strip_cnt;
   logic              valid_out;
   logic [DATA_WD-1:0] data_out;
   logic [W-1:0]      keep_out;
   logic              last_out;
   logic              ready_out;
   logic              drop_pkt;

   typedef struct {
      logic [DATA_WD-1:0] d;
      logic [W-1:0]       k;
      logic               l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] pkt_q[$];
   int         n_checks  = 0;
   int         n_errors  = 0;
   int         exp_drops = 0;
   int         got_drops = 0;
   bit         rand_rdy  = 0;
   bit         p_stall   = 0;
   logic [63:0] p_vec;
   beat_t      mon_e;

   axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .last_in   (last_in),
      .ready_in  (ready_in),
      .strip_cnt (strip_cnt),
      .valid_out (valid_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out),
      .ready_out (ready_out),
      .drop_pkt  (drop_pkt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: drop S leading bytes, then cut the rest into W-byte beats, first byte in the MSB lane.
   task automatic model_pkt(input int s);
      logic [7:0] rem[$];
      beat_t      bt;
      for (int i = s; i < pkt_q.size(); i++) rem.push_back(pkt_q[i]);
      if (rem.size() == 0) begin
         exp_drops++;
      end else begin
         for (int o = 0; o < rem.size(); o += W) begin
            bt.d = '0;
            bt.k = '0;
            for (int j = 0; j < W; j++) begin
               if (o + j < rem.size()) begin
                  bt.d[DATA_WD-1-8*j -: 8] = rem[o+j];
                  bt.k[W-1-j] = 1'b1;
               end
            end
            bt.l = (o + W >= rem.size());
            exp_q.push_back(bt);
         end
      end
   endtask

   task automatic fill_pattern(input int len);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'(8'hA1 + 8'h10 * (i / W) + (i % W)));
   endtask

   task automatic fill_random(input int len);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
   endtask

   // Entered and left at posedge+1; the handshake happens on the posedge in between.
   task automatic send_beat(input logic [DATA_WD-1:0] d, input logic [W-1:0] k,
                            input logic l, input logic [1:0] s);
      int t;
      t = 0;
      valid_in  = 1'b1;
      data_in   = d;
      keep_in   = k;
      last_in   = l;
      strip_cnt = s;
      @(negedge clk);
      while (!ready_in && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      check("ready_in_wait", 64'(t < LIMIT), 64'(1));
      @(posedge clk);
      #1;
      valid_in  = 1'b0;
      data_in   = DATA_WD'($urandom);
      keep_in   = W'($urandom);
      last_in   = 1'($urandom);
      strip_cnt = 2'($urandom);
   endtask

   // Only the first beat carries the real strip_cnt; later beats get noise that must be ignored.
   task automatic send_pkt(input int s, input bit gaps);
      int nb;
      logic [DATA_WD-1:0] d;
      logic [W-1:0] k;
      model_pkt(s);
      nb = (pkt_q.size() + W - 1) / W;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < W; j++) begin
            if (b * W + j < pkt_q.size()) begin
               d[DATA_WD-1-8*j -: 8] = pkt_q[b*W+j];
               k[W-1-j] = 1'b1;
            end else begin
               d[DATA_WD-1-8*j -: 8] = 8'($urandom);
            end
         end
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         send_beat(d, k, b == nb - 1, (b == 0) ? 2'(s - 1) : 2'($urandom));
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < LIMIT) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("drain_done", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: scoreboard compare on each transfer, and stability while stalled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (drop_pkt) got_drops++;
         if (p_stall) begin
            check("stall_valid", 64'(valid_out), 64'(1));
            check("stall_beat", 64'({data_out, keep_out, last_out}), p_vec);
         end
         if (valid_out && ready_out) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("out_data", 64'(data_out), 64'(mon_e.d));
               check("out_keep", 64'(keep_out), 64'(mon_e.k));
               check("out_last", 64'(last_out), 64'(mon_e.l));
            end
         end
         p_stall = valid_out && !ready_out;
         p_vec   = 64'({data_out, keep_out, last_out});
      end else begin
         p_stall = 1'b0;
      end
   end

   initial begin
      rst_n     = 1'b0;
      valid_in  = 1'b0;
      data_in   = '0;
      keep_in   = '0;
      last_in   = 1'b0;
      strip_cnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid_out", 64'(valid_out), 64'(0));
      check("rst_last_out", 64'(last_out), 64'(0));
      check("rst_drop_pkt", 64'(drop_pkt), 64'(0));
      check("rst_keep_out", 64'(keep_out), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));
      check("rst_ready_in", 64'(ready_in), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // S=2 across three beats, last beat exactly fills the output.
      fill_pattern(10);
      send_pkt(2, 0);

      // S=1 with overflow into a residue-only flush beat.
      fill_pattern(7);
      send_pkt(1, 0);
      @(negedge clk);
      check("flush_ready_in_low", 64'(ready_in), 64'(0));
      check("flush_first_last", 64'(last_out), 64'(0));
      @(negedge clk);
      check("flush_ready_in_back", 64'(ready_in), 64'(1));
      check("flush_beat_last", 64'(last_out), 64'(1));
      @(posedge clk);
      #1;

      // S=W: first beat wholly dropped, the rest passes through.
      fill_pattern(9);
      send_pkt(4, 0);

      // Single-beat packet no longer than the header.
      fill_pattern(2);
      send_pkt(3, 0);
      @(negedge clk);
      check("drop_pulse", 64'(drop_pkt), 64'(1));
      check("drop_no_valid", 64'(valid_out), 64'(0));
      @(negedge clk);
      check("drop_pulse_end", 64'(drop_pkt), 64'(0));
      @(posedge clk);
      #1;

      // Single-beat packet that survives stripping.
      fill_pattern(3);
      send_pkt(1, 0);
      drain();

      // Reset after the first beat of a packet; the partial packet must vanish.
      send_beat(32'hA1A2A3A4, 4'b1111, 1'b0, 2'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_valid_out", 64'(valid_out), 64'(0));
      check("midrst_ready_in", 64'(ready_in), 64'(1));
      @(posedge clk);
      #1;
      fill_pattern(10);
      send_pkt(2, 0);
      drain();

      // Random packets, random header length, input gaps and downstream back-pressure.
      rand_rdy = 1;
      fill_pattern(10);
      send_pkt(2, 1);
      for (int p = 0; p < 150; p++) begin
         fill_random($urandom_range(1, 14));
         send_pkt($urandom_range(1, 4), 1);
      end
      rand_rdy = 0;
      drain();

      check("drop_count", 64'(got_drops), 64'(exp_drops));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
